// File: rtl/cvxif_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : cvxif_mem_responder_if
// Description : Bundles the CV-X-IF memory request, response and result
//               channels with the data-memory port of the responder.
//               slave  = responder view, master = coprocessor/memory view.
// Revision    : 1.0 - initial release
// ============================================================================
interface cvxif_mem_responder_if #(
   parameter int ID_W   = 3,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   // x_mem request / response
   logic              x_mem_valid_i;
   logic              x_mem_ready_o;
   logic [ID_W-1:0]   x_mem_req_id_i;
   logic [ADDR_W-1:0] x_mem_req_addr_i;
   logic [1:0]        x_mem_req_mode_i;
   logic              x_mem_req_we_i;
   logic [2:0]        x_mem_req_size_i;
   logic [BE_W-1:0]   x_mem_req_be_i;
   logic [DATA_W-1:0] x_mem_req_wdata_i;
   logic              x_mem_req_last_i;
   logic              x_mem_req_spec_i;
   logic              x_mem_resp_exc_o;
   logic [5:0]        x_mem_resp_exccode_o;

   // x_mem result
   logic              x_mem_result_valid_o;
   logic [ID_W-1:0]   x_mem_result_id_o;
   logic [DATA_W-1:0] x_mem_result_rdata_o;
   logic              x_mem_result_err_o;

   // data-memory port
   logic              data_req_o;
   logic              data_gnt_i;
   logic [ADDR_W-1:0] data_addr_o;
   logic              data_we_o;
   logic [BE_W-1:0]   data_be_o;
   logic [DATA_W-1:0] data_wdata_o;
   logic              data_rvalid_i;
   logic [DATA_W-1:0] data_rdata_i;
   logic              data_err_i;

   modport slave (
      input  x_mem_valid_i, x_mem_req_id_i, x_mem_req_addr_i, x_mem_req_mode_i,
             x_mem_req_we_i, x_mem_req_size_i, x_mem_req_be_i, x_mem_req_wdata_i,
             x_mem_req_last_i, x_mem_req_spec_i,
             data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
      output x_mem_ready_o, x_mem_resp_exc_o, x_mem_resp_exccode_o,
             x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o,
             x_mem_result_err_o,
             data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
   );

   modport master (
      output x_mem_valid_i, x_mem_req_id_i, x_mem_req_addr_i, x_mem_req_mode_i,
             x_mem_req_we_i, x_mem_req_size_i, x_mem_req_be_i, x_mem_req_wdata_i,
             x_mem_req_last_i, x_mem_req_spec_i,
             data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
      input  x_mem_ready_o, x_mem_resp_exc_o, x_mem_resp_exccode_o,
             x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o,
             x_mem_result_err_o,
             data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
   );
endinterface
`default_nettype wire

// File: rtl/cvxif_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cvxif_mem_responder
// Description : Host-side responder for CV-X-IF memory requests. Checks
//               alignment and region, performs one legal access at a time on
//               a req/gnt/rvalid data port and returns the memory result.
// Revision    : 1.0 - initial release
// ============================================================================
module cvxif_mem_responder #(
   parameter int                ID_W        = 3,
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] REGION_BASE = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h1000_0000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   cvxif_mem_responder_if.slave  bus
);
   localparam int BE_W = DATA_W / 8;

   // Word-align mask: clears the byte-offset bits inside one data word
   localparam logic [ADDR_W-1:0] c_addr_mask = ~(ADDR_W'(BE_W - 1));
   // Region bounds extended by one bit so base + size cannot wrap
   localparam logic [ADDR_W:0]   c_region_lo = {1'b0, REGION_BASE};
   localparam logic [ADDR_W:0]   c_region_hi = {1'b0, REGION_BASE} + {1'b0, REGION_SIZE};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT   = 2'd2,
      S_RESULT = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              w_misaligned;
   logic              w_fault;
   logic              w_exc;
   logic [5:0]        w_exccode;
   logic [ADDR_W:0]   w_addr_ext;
   logic              w_idle;

   // Privilege mode and sequence hints do not affect this responder
   logic w_unused_ok;
   assign w_unused_ok = ^{bus.x_mem_req_mode_i, bus.x_mem_req_last_i, bus.x_mem_req_spec_i};

   assign w_idle     = (state_q == S_IDLE);
   assign w_addr_ext = {1'b0, bus.x_mem_req_addr_i};

   // Request legality: misalignment first, then region access fault
   always_comb begin
      w_misaligned = 1'b0;
      case (bus.x_mem_req_size_i)
         3'd0:    w_misaligned = 1'b0;
         3'd1:    w_misaligned = bus.x_mem_req_addr_i[0];
         3'd2:    w_misaligned = |bus.x_mem_req_addr_i[1:0];
         default: w_misaligned = 1'b1;
      endcase
      w_fault   = (w_addr_ext < c_region_lo) || (w_addr_ext >= c_region_hi);
      w_exc     = w_misaligned || w_fault;
      w_exccode = 6'd0;
      if (w_misaligned) begin
         w_exccode = bus.x_mem_req_we_i ? 6'd6 : 6'd4;
      end else if (w_fault) begin
         w_exccode = bus.x_mem_req_we_i ? 6'd7 : 6'd5;
      end
   end

   // Next-state and latch logic for the single outstanding access
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.x_mem_valid_i && !w_exc) begin
               id_d    = bus.x_mem_req_id_i;
               we_d    = bus.x_mem_req_we_i;
               addr_d  = bus.x_mem_req_addr_i;
               be_d    = bus.x_mem_req_be_i;
               wdata_d = bus.x_mem_req_wdata_i;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.data_gnt_i) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.data_rvalid_i) begin
               rdata_d = we_q ? '0 : bus.data_rdata_i;
               err_d   = bus.data_err_i;
               state_d = S_RESULT;
            end
         end
         S_RESULT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latched request/result registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         id_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.x_mem_ready_o        = w_idle;
   assign bus.x_mem_resp_exc_o     = w_idle & w_exc;
   assign bus.x_mem_resp_exccode_o = w_idle ? w_exccode : 6'd0;

   assign bus.x_mem_result_valid_o = (state_q == S_RESULT);
   assign bus.x_mem_result_id_o    = id_q;
   assign bus.x_mem_result_rdata_o = rdata_q;
   assign bus.x_mem_result_err_o   = err_q;

   assign bus.data_req_o   = (state_q == S_REQ);
   assign bus.data_addr_o  = addr_q & c_addr_mask;
   assign bus.data_we_o    = we_q;
   assign bus.data_be_o    = be_q;
   assign bus.data_wdata_o = wdata_q;

endmodule
`default_nettype wire
